// File: rtl/mul_reservation_station.sv
// Reservation station for the multiply/divide unit: holds issued instructions until both
// operands are captured (at issue or via CDB snoop), then offers the oldest ready entry.
module mul_reservation_station #(
  parameter int NUM_ENTRIES = 3,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 issue_valid,
  input  logic [2:0]                           issue_op,
  input  logic [31:0]                          issue_vj,
  input  logic [31:0]                          issue_vk,
  input  logic                                 issue_qj_pend,
  input  logic                                 issue_qk_pend,
  input  logic [TAG_WIDTH-1:0]                 issue_qj,
  input  logic [TAG_WIDTH-1:0]                 issue_qk,
  input  logic [TAG_WIDTH-1:0]                 issue_tag,
  output logic                                 issue_ready,
  input  logic                                 cdb_valid,
  input  logic [TAG_WIDTH-1:0]                 cdb_tag,
  input  logic [31:0]                          cdb_data,
  output logic                                 dispatch_valid,
  output logic [2:0]                           dispatch_op,
  output logic [31:0]                          dispatch_vj,
  output logic [31:0]                          dispatch_vk,
  output logic [TAG_WIDTH-1:0]                 dispatch_tag,
  input  logic                                 dispatch_ack,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]     count
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(NUM_ENTRIES + 1);
  localparam int IDX_W  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int AGE_W  = $clog2(NUM_ENTRIES) + 2;

  logic                 busy    [NUM_ENTRIES];
  logic [2:0]           ent_op  [NUM_ENTRIES];
  logic [DATA_W-1:0]    ent_vj  [NUM_ENTRIES];
  logic [DATA_W-1:0]    ent_vk  [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0] ent_qj  [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0] ent_qk  [NUM_ENTRIES];
  logic                 ent_pj  [NUM_ENTRIES];
  logic                 ent_pk  [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0] ent_tag [NUM_ENTRIES];
  logic [AGE_W-1:0]     ent_age [NUM_ENTRIES];

  logic [CNT_W-1:0]  busy_cnt;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [AGE_W-1:0]  sel_age;
  logic              issue_fire;
  logic              dispatch_fire;
  logic              byp_j;
  logic              byp_k;
  logic [DATA_W-1:0] new_vj;
  logic [DATA_W-1:0] new_vk;

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (a == {AGE_W{1'b1}}) ? a : a + 1'b1;
  endfunction

  always_comb begin
    busy_cnt   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      busy_cnt = busy_cnt + CNT_W'(busy[i]);
      if (!busy[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Strict '>' keeps the lowest index on equal (e.g. saturated) ages.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (busy[i] && !ent_pj[i] && !ent_pk[i] && (!sel_found || ent_age[i] > sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = ent_age[i];
      end
    end
  end

  assign count         = busy_cnt;
  assign issue_ready   = busy_cnt < CNT_W'(NUM_ENTRIES);
  assign issue_fire    = issue_valid && issue_ready && free_found;
  assign dispatch_fire = sel_found && dispatch_ack;

  assign byp_j  = cdb_valid && issue_qj_pend && (issue_qj == cdb_tag);
  assign byp_k  = cdb_valid && issue_qk_pend && (issue_qk == cdb_tag);
  assign new_vj = byp_j ? cdb_data : issue_vj;
  assign new_vk = byp_k ? cdb_data : issue_vk;

  always_comb begin
    dispatch_valid = sel_found;
    dispatch_op    = '0;
    dispatch_vj    = '0;
    dispatch_vk    = '0;
    dispatch_tag   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (sel_found && IDX_W'(i) == sel_idx) begin
        dispatch_op  = ent_op[i];
        dispatch_vj  = ent_vj[i];
        dispatch_vk  = ent_vk[i];
        dispatch_tag = ent_tag[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        busy[i]    <= 1'b0;
        ent_op[i]  <= '0;
        ent_vj[i]  <= '0;
        ent_vk[i]  <= '0;
        ent_qj[i]  <= '0;
        ent_qk[i]  <= '0;
        ent_pj[i]  <= 1'b0;
        ent_pk[i]  <= 1'b0;
        ent_tag[i] <= '0;
        ent_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (issue_fire && IDX_W'(i) == free_idx) begin
          busy[i]    <= 1'b1;
          ent_op[i]  <= issue_op;
          ent_vj[i]  <= new_vj;
          ent_vk[i]  <= new_vk;
          ent_qj[i]  <= issue_qj;
          ent_qk[i]  <= issue_qk;
          ent_pj[i]  <= issue_qj_pend && !byp_j;
          ent_pk[i]  <= issue_qk_pend && !byp_k;
          ent_tag[i] <= issue_tag;
          ent_age[i] <= '0;
        end else if (busy[i]) begin
          if (dispatch_fire && IDX_W'(i) == sel_idx)
            busy[i] <= 1'b0;
          if (cdb_valid && ent_pj[i] && ent_qj[i] == cdb_tag) begin
            ent_vj[i] <= cdb_data;
            ent_pj[i] <= 1'b0;
          end
          if (cdb_valid && ent_pk[i] && ent_qk[i] == cdb_tag) begin
            ent_vk[i] <= cdb_data;
            ent_pk[i] <= 1'b0;
          end
          if (issue_fire)
            ent_age[i] <= age_sat_inc(ent_age[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_reservation_station.sv
// Bench for mul_reservation_station: directed scenarios plus random traffic, checked each
// cycle against a slot-array model that derives age from issue sequence numbers.
module tb_mul_reservation_station;

  localparam int N       = 3;
  localparam int TW      = 4;
  localparam int AGE_MAX = (1 << ($clog2(N) + 2)) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid;
  logic [2:0]    issue_op;
  logic [31:0]   issue_vj, issue_vk;
  logic          issue_qj_pend, issue_qk_pend;
  logic [TW-1:0] issue_qj, issue_qk, issue_tag;
  logic          issue_ready;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [31:0]   cdb_data;
  logic          dispatch_valid;
  logic [2:0]    dispatch_op;
  logic [31:0]   dispatch_vj, dispatch_vk;
  logic [TW-1:0] dispatch_tag;
  logic          dispatch_ack;
  logic [1:0]    count;

  always #5 clk = ~clk;

  mul_reservation_station #(.NUM_ENTRIES(N), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_pend(issue_qj_pend), .issue_qk_pend(issue_qk_pend),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_tag(issue_tag), .issue_ready(issue_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op), .dispatch_vj(dispatch_vj),
    .dispatch_vk(dispatch_vk), .dispatch_tag(dispatch_tag), .dispatch_ack(dispatch_ack),
    .count(count)
  );

  typedef struct {
    bit          busy;
    logic [2:0]  op;
    logic [31:0] vj, vk;
    logic [3:0]  qj, qk;
    bit          pj, pk;
    logic [3:0]  tag;
    int          seq;
  } slot_t;

  slot_t m[N];
  int    issue_cnt;
  int    vectors;
  int    errs;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int m_age(input int s);
    int a = issue_cnt - m[s].seq - 1;
    return (a > AGE_MAX) ? AGE_MAX : a;
  endfunction

  function automatic int m_sel();
    int best = -1;
    for (int i = 0; i < N; i++)
      if (m[i].busy && !m[i].pj && !m[i].pk && (best < 0 || m_age(i) > m_age(best)))
        best = i;
    return best;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m[i].busy;
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m[i].busy = 0;
    issue_cnt = 0;
  endtask

  task automatic check_outputs();
    int s = m_sel();
    chk("dispatch_valid", dispatch_valid, (s >= 0) ? 1 : 0);
    if (s >= 0) begin
      chk("dispatch_op", dispatch_op, m[s].op);
      chk("dispatch_vj", dispatch_vj, m[s].vj);
      chk("dispatch_vk", dispatch_vk, m[s].vk);
      chk("dispatch_tag", dispatch_tag, m[s].tag);
    end else begin
      chk("dispatch_op_idle", dispatch_op, 0);
      chk("dispatch_vj_idle", dispatch_vj, 0);
      chk("dispatch_vk_idle", dispatch_vk, 0);
      chk("dispatch_tag_idle", dispatch_tag, 0);
    end
    chk("issue_ready", issue_ready, (m_count() < N) ? 1 : 0);
    chk("count", count, m_count());
  endtask

  task automatic m_clock();
    int  s = m_sel();
    int  fr = -1;
    bit  ifire = issue_valid && (m_count() < N);
    for (int i = 0; i < N; i++)
      if (!m[i].busy && fr < 0) fr = i;
    for (int i = 0; i < N; i++) begin
      if (m[i].busy && cdb_valid && m[i].pj && m[i].qj == cdb_tag) begin
        m[i].vj = cdb_data; m[i].pj = 0;
      end
      if (m[i].busy && cdb_valid && m[i].pk && m[i].qk == cdb_tag) begin
        m[i].vk = cdb_data; m[i].pk = 0;
      end
    end
    if (s >= 0 && dispatch_ack) m[s].busy = 0;
    if (ifire) begin
      m[fr].busy = 1;
      m[fr].op   = issue_op;
      m[fr].tag  = issue_tag;
      m[fr].qj   = issue_qj;
      m[fr].qk   = issue_qk;
      m[fr].pj   = issue_qj_pend && !(cdb_valid && issue_qj == cdb_tag);
      m[fr].pk   = issue_qk_pend && !(cdb_valid && issue_qk == cdb_tag);
      m[fr].vj   = (issue_qj_pend && !m[fr].pj) ? cdb_data : issue_vj;
      m[fr].vk   = (issue_qk_pend && !m[fr].pk) ? cdb_data : issue_vk;
      m[fr].seq  = issue_cnt;
      issue_cnt++;
    end
  endtask

  // Inputs are set after a falling edge; this checks, clocks the model and returns at the next falling edge.
  task automatic cycle();
    #1 check_outputs();
    @(posedge clk);
    m_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 0; issue_op = 0; issue_vj = 0; issue_vk = 0;
    issue_qj_pend = 0; issue_qk_pend = 0; issue_qj = 0; issue_qk = 0; issue_tag = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; dispatch_ack = 0;
  endtask

  task automatic set_issue(input logic [2:0] op, input logic [31:0] vj, input logic [31:0] vk,
                           input logic pj, input logic [3:0] qj, input logic pk,
                           input logic [3:0] qk, input logic [3:0] tag);
    issue_valid = 1; issue_op = op; issue_vj = vj; issue_vk = vk;
    issue_qj_pend = pj; issue_qj = qj; issue_qk_pend = pk; issue_qk = qk; issue_tag = tag;
  endtask

  initial begin
    vectors = 0;
    errs = 0;
    idle();
    m_reset();
    repeat (2) @(negedge clk);
    #1 check_outputs();
    rst_n = 1;

    // Ready issue, one-cycle latency, ack drains
    set_issue(3'd1, 32'd6, 32'd7, 0, 0, 0, 0, 4'd2);
    cycle();
    idle();
    #1 chk("tp1_valid", dispatch_valid, 1);
    chk("tp1_vj", dispatch_vj, 6);
    chk("tp1_vk", dispatch_vk, 7);
    chk("tp1_tag", dispatch_tag, 2);
    dispatch_ack = 1;
    cycle();
    idle();
    #1 chk("tp1_count", count, 0);

    // CDB wakeup: not eligible in broadcast cycle
    set_issue(3'd2, 32'd0, 32'd3, 1, 4'd5, 0, 0, 4'd1);
    cycle();
    idle();
    cycle();
    cdb_valid = 1; cdb_tag = 4'd5; cdb_data = 32'd9;
    #1 chk("tp2_bcast_valid", dispatch_valid, 0);
    cycle();
    idle();
    #1 chk("tp2_valid", dispatch_valid, 1);
    chk("tp2_vj", dispatch_vj, 9);
    chk("tp2_vk", dispatch_vk, 3);
    dispatch_ack = 1;
    cycle();
    idle();

    // Issue bypass from coincident broadcast
    set_issue(3'd3, 32'd0, 32'd5, 1, 4'd4, 0, 0, 4'd3);
    cdb_valid = 1; cdb_tag = 4'd4; cdb_data = 32'd11;
    cycle();
    idle();
    #1 chk("tp3_valid", dispatch_valid, 1);
    chk("tp3_vj", dispatch_vj, 11);
    dispatch_ack = 1;
    cycle();
    idle();

    // Fill, ignore a fourth issue, one ack
    for (int t = 1; t <= 3; t++) begin
      set_issue(3'd1, 32'(t * 10), 32'(t), 0, 0, 0, 0, 4'(t));
      cycle();
    end
    idle();
    #1 chk("tp4_ready", issue_ready, 0);
    chk("tp4_count", count, 3);
    chk("tp4_tag", dispatch_tag, 1);
    set_issue(3'd1, 32'd99, 32'd99, 0, 0, 0, 0, 4'd4);
    cycle();
    idle();
    #1 chk("tp4_count_full", count, 3);
    dispatch_ack = 1;
    cycle();
    dispatch_ack = 0;
    #1 chk("tp4_next_tag", dispatch_tag, 2);
    chk("tp4_ready_again", issue_ready, 1);
    dispatch_ack = 1;
    cycle();
    cycle();
    idle();

    // Older pending entry vs younger ready entry
    set_issue(3'd4, 32'd0, 32'd1, 1, 4'd6, 0, 0, 4'd1);
    cycle();
    set_issue(3'd5, 32'd2, 32'd3, 0, 0, 0, 0, 4'd2);
    cycle();
    idle();
    #1 chk("tp5_first", dispatch_tag, 2);
    cdb_valid = 1; cdb_tag = 4'd6; cdb_data = 32'h55;
    dispatch_ack = 1;
    cycle();
    idle();
    #1 chk("tp5_second", dispatch_tag, 1);
    chk("tp5_vj", dispatch_vj, 32'h55);
    dispatch_ack = 1;
    cycle();
    idle();

    // Asynchronous reset mid-cycle
    set_issue(3'd1, 32'd1, 32'd2, 0, 0, 0, 0, 4'd1);
    cycle();
    set_issue(3'd1, 32'd3, 32'd4, 0, 0, 0, 0, 4'd2);
    cycle();
    idle();
    #2 rst_n = 0;
    m_reset();
    #1 chk("tp6_count", count, 0);
    chk("tp6_valid", dispatch_valid, 0);
    @(negedge clk);
    rst_n = 1;
    set_issue(3'd6, 32'd8, 32'd9, 0, 0, 0, 0, 4'd7);
    cycle();
    idle();
    #1 chk("tp6_tag", dispatch_tag, 7);
    chk("tp6_vj", dispatch_vj, 8);
    dispatch_ack = 1;
    cycle();
    idle();

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      issue_valid   = ($urandom_range(0, 9) < 6);
      issue_op      = 3'($urandom);
      issue_vj      = $urandom;
      issue_vk      = $urandom;
      issue_qj_pend = ($urandom_range(0, 9) < 4);
      issue_qk_pend = ($urandom_range(0, 9) < 4);
      issue_qj      = 4'($urandom_range(1, 7));
      issue_qk      = 4'($urandom_range(1, 7));
      issue_tag     = 4'($urandom);
      cdb_valid     = ($urandom_range(0, 9) < 4);
      cdb_tag       = 4'($urandom_range(1, 7));
      cdb_data      = $urandom;
      dispatch_ack  = ($urandom_range(0, 9) < 5);
      cycle();
    end
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
